// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : cpu_mem_responder
// Brief   : Byte-wide CPU memory responder: RAM plus TX FIFO / RX / STATUS /
//           LEDS I/O window in the top four addresses, with post-reset clear.
// Rev     : 1.0  initial release
// ============================================================================
module cpu_mem_responder #(
    parameter int ADDR_WIDTH     = 9,
    parameter int FIFO_DEPTH     = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [7:0]            mem_data_out,
    input  logic [ADDR_WIDTH-1:0] mem_waddr,
    input  logic [7:0]            mem_data_in,
    input  logic                  mem_write,
    output logic                  mem_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_strobe,
    output logic [7:0]            leds
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0] c_FIFO_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_ready;
    logic [ADDR_WIDTH-1:0]   r_clr_addr;
    logic [7:0]              r_data_out;
    logic [7:0]              r_mem [0:c_DEPTH-1];

    logic [7:0]              r_fifo [0:FIFO_DEPTH-1];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_PTR_W:0]        r_count;
    logic                    r_tx_overflow;

    logic [7:0]              r_rx_byte;
    logic                    r_rx_valid;
    logic                    r_rx_overrun;
    logic [7:0]              r_leds;

    logic                    w_wr_io;
    logic                    w_rd_io;
    logic                    w_wr_txdata;
    logic                    w_wr_status;
    logic                    w_wr_rxdata;
    logic                    w_wr_leds;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_pop;
    logic                    w_push_ok;
    logic                    w_overflow_evt;
    logic                    w_overrun_evt;
    logic                    w_ram_we;
    logic [ADDR_WIDTH-1:0]   w_ram_addr;
    logic [7:0]              w_ram_wdata;
    logic [7:0]              w_status;
    logic [7:0]              w_rd_byte;

    // I/O window = the four addresses whose upper bits are all ones
    assign w_wr_io = &mem_waddr[ADDR_WIDTH-1:2];
    assign w_rd_io = &mem_raddr[ADDR_WIDTH-1:2];

    assign w_wr_txdata = r_ready && mem_write && w_wr_io && (mem_waddr[1:0] == 2'b00);
    assign w_wr_status = r_ready && mem_write && w_wr_io && (mem_waddr[1:0] == 2'b01);
    assign w_wr_rxdata = r_ready && mem_write && w_wr_io && (mem_waddr[1:0] == 2'b10);
    assign w_wr_leds   = r_ready && mem_write && w_wr_io && (mem_waddr[1:0] == 2'b11);

    assign w_fifo_full    = (r_count == c_FIFO_FULL);
    assign w_fifo_empty   = (r_count == '0);
    assign w_pop          = !w_fifo_empty && tx_ready;
    // A push into a full FIFO survives only if a pop frees the head slot
    assign w_push_ok      = w_wr_txdata && (!w_fifo_full || w_pop);
    assign w_overflow_evt = w_wr_txdata && w_fifo_full && !w_pop;
    assign w_overrun_evt  = rx_strobe && r_rx_valid;

    assign w_ram_we    = !reset && ((r_state == S_CLEAR) ||
                                    (r_ready && mem_write && !w_wr_io));
    assign w_ram_addr  = (r_state == S_CLEAR) ? r_clr_addr : mem_waddr;
    assign w_ram_wdata = (r_state == S_CLEAR) ? 8'h00 : mem_data_in;

    assign w_status = {3'b000, r_rx_overrun, r_tx_overflow, r_rx_valid,
                       w_fifo_empty, w_fifo_full};

    always_comb begin
        w_rd_byte = r_mem[mem_raddr];
        if (w_rd_io) begin
            case (mem_raddr[1:0])
                2'b00:   w_rd_byte = 8'h00;
                2'b01:   w_rd_byte = w_status;
                2'b10:   w_rd_byte = r_rx_byte;
                default: w_rd_byte = r_leds;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_ram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= mem_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            r_ready       <= 1'b0;
            r_clr_addr    <= '0;
            r_data_out    <= 8'h00;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_tx_overflow <= 1'b0;
            r_rx_byte     <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_leds        <= 8'h00;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_data_out <= 8'h00;
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (&r_clr_addr) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_ready    <= 1'b1;
                    r_data_out <= r_ready ? w_rd_byte : 8'h00;
                end
            endcase

            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // New events take priority over a STATUS write clearing the flags
            if (w_overflow_evt) begin
                r_tx_overflow <= 1'b1;
            end else if (w_wr_status) begin
                r_tx_overflow <= 1'b0;
            end
            if (w_overrun_evt) begin
                r_rx_overrun <= 1'b1;
            end else if (w_wr_status) begin
                r_rx_overrun <= 1'b0;
            end

            if (rx_strobe) begin
                r_rx_byte  <= rx_data;
                r_rx_valid <= 1'b1;
            end else if (w_wr_rxdata) begin
                r_rx_valid <= 1'b0;
            end

            if (w_wr_leds) begin
                r_leds <= mem_data_in;
            end
        end
    end

    assign mem_data_out = r_data_out;
    assign mem_ready    = r_ready;
    assign tx_data      = r_fifo[r_rd_ptr];
    assign tx_valid     = !w_fifo_empty;
    assign leds         = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_mem_responder
// Brief   : Directed vector table plus hand sequences for cpu_mem_responder.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cpu_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] mem_raddr;
    logic [7:0] mem_data_out;
    logic [8:0] mem_waddr;
    logic [7:0] mem_data_in;
    logic       mem_write;
    logic       mem_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic [7:0] leds;

    int checks = 0;
    int errors = 0;

    cpu_mem_responder #(
        .ADDR_WIDTH     (9),
        .FIFO_DEPTH     (4),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_raddr    (mem_raddr),
        .mem_data_out (mem_data_out),
        .mem_waddr    (mem_waddr),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .mem_ready    (mem_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_strobe    (rx_strobe),
        .leds         (leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [8:0] waddr;
        logic [7:0] wdata;
        logic [8:0] raddr;
        logic [7:0] exp_dout;
        logic [7:0] exp_leds;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [8:0] a, input logic [7:0] d);
        mem_write   = 1'b1;
        mem_waddr   = a;
        mem_data_in = d;
        tick();
        mem_write   = 1'b0;
    endtask

    task automatic rd(input logic [8:0] a);
        mem_raddr = a;
        tick();
    endtask

    task automatic wait_ready(input string name);
        int cnt = 0;
        while (!mem_ready && cnt < 2000) begin
            tick();
            cnt++;
        end
        check(name, cnt, 512);
    endtask

    initial begin
        reset = 1'b1; mem_raddr = '0; mem_waddr = '0; mem_data_in = '0;
        mem_write = 1'b0; tx_ready = 1'b0; rx_data = '0; rx_strobe = 1'b0;

        vecs[0]  = '{1'b1, 9'h020, 8'hA5, 9'h010, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 9'h021, 8'h5A, 9'h020, 8'hA5, 8'h00};
        vecs[2]  = '{1'b0, 9'h000, 8'h00, 9'h021, 8'h5A, 8'h00};
        vecs[3]  = '{1'b1, 9'h030, 8'h11, 9'h000, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 9'h030, 8'h77, 9'h030, 8'h11, 8'h00};
        vecs[5]  = '{1'b0, 9'h000, 8'h00, 9'h030, 8'h77, 8'h00};
        vecs[6]  = '{1'b1, 9'h1FB, 8'h5E, 9'h1FB, 8'h00, 8'h00};
        vecs[7]  = '{1'b1, 9'h1FF, 8'hC3, 9'h1FF, 8'h00, 8'hC3};
        vecs[8]  = '{1'b0, 9'h000, 8'h00, 9'h1FF, 8'hC3, 8'hC3};
        vecs[9]  = '{1'b0, 9'h000, 8'h00, 9'h1FB, 8'h5E, 8'hC3};
        vecs[10] = '{1'b0, 9'h000, 8'h00, 9'h1FC, 8'h00, 8'hC3};
        vecs[11] = '{1'b0, 9'h000, 8'h00, 9'h1FD, 8'h02, 8'hC3};

        repeat (3) tick();
        check("reset_ready", mem_ready, 0);
        check("reset_dout", mem_data_out, 0);
        check("reset_tx_valid", tx_valid, 0);
        check("reset_leds", leds, 0);

        reset = 1'b0;
        wait_ready("clear_cycles");

        for (int i = 0; i < 12; i++) begin
            mem_write   = vecs[i].we;
            mem_waddr   = vecs[i].waddr;
            mem_data_in = vecs[i].wdata;
            mem_raddr   = vecs[i].raddr;
            tick();
            check($sformatf("vec%0d_dout", i), mem_data_out, vecs[i].exp_dout);
            check($sformatf("vec%0d_leds", i), leds, vecs[i].exp_leds);
        end
        mem_write = 1'b0;

        // TX FIFO: fill, overflow, drain
        for (int i = 0; i < 5; i++) wr(9'h1FC, 8'(8'h41 + i));
        rd(9'h1FD);
        check("tx_full_status", mem_data_out, 8'h09);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tx_valid_%0d", i), tx_valid, 1);
            check($sformatf("tx_data_%0d", i), tx_data, 8'h41 + i);
            tick();
        end
        check("tx_drained", tx_valid, 0);
        tx_ready = 1'b0;
        rd(9'h1FD);
        check("tx_empty_status", mem_data_out, 8'h0A);
        mem_write = 1'b1; mem_waddr = 9'h1FD; mem_data_in = 8'hFF;
        tick();
        mem_write = 1'b0;
        check("status_rbw", mem_data_out, 8'h0A);
        tick();
        check("status_cleared", mem_data_out, 8'h02);

        // push while full with simultaneous pop is accepted
        for (int i = 0; i < 4; i++) wr(9'h1FC, 8'(8'h60 + i));
        tx_ready = 1'b1;
        wr(9'h1FC, 8'h64);
        tx_ready = 1'b0;
        rd(9'h1FD);
        check("full_pushpop_status", mem_data_out, 8'h01);
        check("full_pushpop_head", tx_data, 8'h61);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain2_%0d", i), tx_data, 8'h61 + i);
            tick();
        end
        check("drain2_empty", tx_valid, 0);
        // push+ready on empty: push only
        wr(9'h1FC, 8'h70);
        check("empty_push_valid", tx_valid, 1);
        check("empty_push_data", tx_data, 8'h70);
        tick();
        check("empty_push_popped", tx_valid, 0);
        tx_ready = 1'b0;

        // RX latch and overrun
        rx_data = 8'h33; rx_strobe = 1'b1; tick();
        rx_data = 8'h44; tick();
        rx_strobe = 1'b0;
        rd(9'h1FE);
        check("rxdata", mem_data_out, 8'h44);
        rd(9'h1FD);
        check("rx_overrun_status", mem_data_out, 8'h16);
        wr(9'h1FE, 8'h00);
        tick();
        check("rx_valid_cleared", mem_data_out, 8'h12);
        rx_data = 8'h55; rx_strobe = 1'b1;
        wr(9'h1FE, 8'h00);
        rx_strobe = 1'b0;
        tick();
        check("rx_strobe_wins", mem_data_out, 8'h16);
        rx_data = 8'h66; rx_strobe = 1'b1;
        wr(9'h1FD, 8'h00);
        rx_strobe = 1'b0;
        tick();
        check("event_beats_clear", mem_data_out, 8'h16);
        wr(9'h1FD, 8'h00);
        tick();
        check("flags_cleared", mem_data_out, 8'h06);
        rd(9'h1FE);
        check("rxdata_latest", mem_data_out, 8'h66);

        // reset mid-sweep restarts the full clear
        reset = 1'b1; tick(); reset = 1'b0;
        repeat (100) tick();
        check("midclear_ready_low", mem_ready, 0);
        reset = 1'b1; tick();
        check("reset2_leds", leds, 0);
        reset = 1'b0;
        wait_ready("clear_restart_cycles");
        rd(9'h020);
        check("ram_cleared", mem_data_out, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Responder end of the CPU byte-wide memory interface: on-chip RAM plus a small memory-mapped I/O window at the top of the address space.
- The CPU drives mem_raddr, mem_waddr, mem_data_in and mem_write. This block returns mem_data_out and mem_ready.
- The I/O window contains a TX byte FIFO feeding a serial transmitter, a latched RX byte from a serial receiver, a status register and an LED register.
- An optional RAM-clear sweep runs after reset. Top level holds the CPU in reset while mem_ready is low.

Parameters:
- addr_width, 9, byte address width; address space is 2**addr_width bytes.
- fifo_depth, 4, TX FIFO entries; power of two, at least 2.
- clear_on_reset, 1, when 1, RAM is zeroed after reset before mem_ready rises.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- mem_raddr  input  addr_width  read byte address from CPU
- mem_data_out  output  8  read data to CPU
- mem_waddr  input  addr_width  write byte address from CPU
- mem_data_in  input  8  write data from CPU
- mem_write  input  1  write strobe, one cycle per byte
- mem_ready  output  1  high when the responder accepts traffic
- tx_data  output  8  head byte of the TX FIFO
- tx_valid  output  1  TX FIFO not empty
- tx_ready  input  1  transmitter accepts tx_data this cycle
- rx_data  input  8  received byte
- rx_strobe  input  1  one-cycle pulse: rx_data valid
- leds  output  8  LED register

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - mem_data_out=0, mem_ready=0, tx_valid=0, leds=0.
  - FIFO pointers and count cleared; rx_valid=0; overflow and overrun flags cleared.
  - RAM contents are not reset, except through the clear sweep.
- Address map (A = 2**addr_width):
  - 0..A-5: RAM.
  - A-4 TXDATA: write pushes a byte; reads as 0.
  - A-3 STATUS, read:
    - bit0 fifo_full, bit1 fifo_empty, bit2 rx_valid
    - bit3 tx_overflow (sticky), bit4 rx_overrun (sticky), bits7:5 = 0.
    - Any write clears bits 3 and 4.
  - A-2 RXDATA: read returns the latched RX byte; any write clears rx_valid.
  - A-1 LEDS: read/write, drives leds.
  - RAM cells shadowed by I/O addresses are never written.
- States: CLEAR, RUN.
  - After reset the state is CLEAR if clear_on_reset=1, else RUN.
  - In CLEAR, a counter writes 0 to RAM addresses 0..A-1, one per cycle, for A cycles; then the state goes to RUN.
  - mem_ready=1 only in RUN. mem_write and reads are ignored in CLEAR, and mem_data_out holds 0.
  - Reset asserted mid-CLEAR restarts the sweep from address 0.
- Read timing:
  - mem_data_out is registered: the byte at mem_raddr sampled on edge N appears after edge N and is valid at edge N+1.
  - One new address per cycle is supported with one-cycle latency. This meets the CPU's rule of two edges between loading mem_raddr and sampling data.
  - Reads have no side effects; a held address repeatedly returns current contents.
- Write timing: on an edge with mem_write=1, mem_data_in is committed to mem_waddr (RAM or I/O).
- Simultaneous read and write to the same RAM address: read-before-write. mem_data_out gets the old byte and the new value is visible one cycle later. The same rule applies to the LEDS, STATUS and RXDATA registers.
- TX FIFO:
  - tx_data always shows the head entry; tx_valid = count != 0.
  - Pop on tx_valid & tx_ready.
  - A push when full with no pop in the same cycle is dropped and sets tx_overflow.
  - A push when full with a pop in the same cycle is accepted; count is unchanged.
  - Simultaneous push and pop on an empty FIFO: push only, since tx_valid was 0.
  - Pointers wrap modulo fifo_depth; count is log2(fifo_depth)+1 bits.
- RX register:
  - rx_strobe latches rx_data and sets rx_valid.
  - A strobe while rx_valid=1 overwrites the byte and sets rx_overrun.
  - rx_strobe in the same cycle as a write to RXDATA: the new byte wins and rx_valid stays 1.
- STATUS write in the same cycle as a new overflow or overrun event: the event wins and the flag stays 1.

Test Plan:
- Reset with clear_on_reset=1, addr_width=9 -> mem_ready low for exactly 512 cycles, then high; read of address 0x010 returns 0x00.
- Write 0xA5 to 0x020 and 0x5A to 0x021, then present raddr 0x020 and 0x021 on consecutive cycles -> mem_data_out shows 0xA5 then 0x5A, each one cycle after its address.
- Same-cycle write of 0x77 and read of 0x030 (old value 0x11) -> 0x11 returned; a re-read returns 0x77.
- tx_ready=0, write 0x41..0x45 to 0x1FC -> STATUS reads 0x09 (full plus overflow); raise tx_ready -> tx_data emits 0x41..0x44 then tx_valid=0; STATUS reads 0x0A; write to 0x1FD -> STATUS reads 0x02.
- rx_strobe with 0x33, then rx_strobe with 0x44 -> RXDATA reads 0x44 and STATUS reads 0x16; write 0x1FE -> STATUS bit2 clears.
- Write 0xC3 to 0x1FF -> leds=0xC3 the cycle after the write; read of 0x1FF returns 0xC3; RAM read of 0x1FB is unaffected.
